fifo_param: RTL and testbench

Parametrised synchronous FIFO for the UART datapath and other byte/word streams in the design. Generalises the fixed 8×8 UART FIFO to configurable data width and depth, adds a first-word-fall-through (FWFT) read mode, an occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow and underflow error flags. It sits between a producer (for example UART RX or sensor capture) and a consumer (for example UART TX or the command decoder). Both sides share one clock.

---
 rtl/fifo_param_if.sv | 34 +++
 rtl/fifo_param.sv | 94 +++++++++
 tb/tb_fifo_param.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_param_if.sv
// Push/pop handshake and status bundle for fifo_param.
// master drives requests; slave is the FIFO itself.
interface fifo_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  iPush;
  logic [DATA_WIDTH-1:0] iWrData;
  logic                  iPop;
  logic                  iClrErr;
  logic [DATA_WIDTH-1:0] oRdData;
  logic                  oRdValid;
  logic                  oFull;
  logic                  oEmpty;
  logic                  oAlmostFull;
  logic                  oAlmostEmpty;
  logic [ADDR_WIDTH:0]   oCount;
  logic                  oOverflow;
  logic                  oUnderflow;

  modport master (
    output iPush, iWrData, iPop, iClrErr,
    input  oRdData, oRdValid, oFull, oEmpty,
    input  oAlmostFull, oAlmostEmpty, oCount,
    input  oOverflow, oUnderflow
  );

  modport slave (
    input  iPush, iWrData, iPop, iClrErr,
    output oRdData, oRdValid, oFull, oEmpty,
    output oAlmostFull, oAlmostEmpty, oCount,
    output oOverflow, oUnderflow
  );
endinterface

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with registered or
// fall-through read, occupancy count and sticky error flags.
module fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 1
) (
  input logic         iClk,
  input logic         iRst,
  fifo_param_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DepthC = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AfC = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AeC = AE_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] CntOne = 1;
  localparam logic [ADDR_WIDTH-1:0] PtrOne = 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wrPtr;
  logic [ADDR_WIDTH-1:0] rdPtr;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic                  pushOk;
  logic                  popOk;
  logic                  overflow;
  logic                  underflow;

  assign full   = (count == DepthC);
  assign empty  = (count == '0);
  assign popOk  = bus.iPop & ~empty;
  assign pushOk = bus.iPush & (~full | popOk);

  assign bus.oFull        = full;
  assign bus.oEmpty       = empty;
  assign bus.oAlmostFull  = (count >= AfC);
  assign bus.oAlmostEmpty = (count <= AeC);
  assign bus.oCount       = count;
  assign bus.oOverflow    = overflow;
  assign bus.oUnderflow   = underflow;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + PtrOne;
      if (popOk)  rdPtr <= rdPtr + PtrOne;
      case ({pushOk, popOk})
        2'b10:   count <= count + CntOne;
        2'b01:   count <= count - CntOne;
        default: count <= count;
      endcase
      // a new error in the same cycle as a clear still sticks
      overflow  <= (bus.iPush & ~pushOk)
                 | (overflow & ~bus.iClrErr);
      underflow <= (bus.iPop & ~popOk)
                 | (underflow & ~bus.iClrErr);
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst && pushOk) mem[wrPtr] <= bus.iWrData;
  end

  generate
    if (FWFT != 0) begin : gFwft
      assign bus.oRdData  = empty ? '0 : mem[rdPtr];
      assign bus.oRdValid = ~empty;
    end else begin : gReg
      logic [DATA_WIDTH-1:0] rdData;
      logic                  rdValid;

      always_ff @(posedge iClk) begin
        if (iRst) begin
          rdData  <= '0;
          rdValid <= 1'b0;
        end else begin
          rdValid <= popOk;
          if (popOk) rdData <= mem[rdPtr];
        end
      end

      assign bus.oRdData  = rdData;
      assign bus.oRdValid = rdValid;
    end
  endgenerate
endmodule

// File: tb/tb_fifo_param.sv
// Randomised scoreboard bench for fifo_param in both read modes.
// Reference is a plain queue model of FIFO occupancy.
module tb_fifo_param;
  logic clk;
  logic rstA;
  logic rstB;
  int   total;
  int   bad;
  bit   armB;

  fifo_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bA ();
  fifo_param_if #(.DATA_WIDTH(16), .ADDR_WIDTH(2)) bB ();

  fifo_param #(
    .DATA_WIDTH(8), .ADDR_WIDTH(3), .FWFT(0),
    .AF_LEVEL(6), .AE_LEVEL(1)
  ) dutA (.iClk(clk), .iRst(rstA), .bus(bA));

  fifo_param #(
    .DATA_WIDTH(16), .ADDR_WIDTH(2), .FWFT(1),
    .AF_LEVEL(3), .AE_LEVEL(1)
  ) dutB (.iClk(clk), .iRst(rstB), .bus(bB));

  logic [7:0]  qA [$];
  logic [7:0]  expA [$];
  logic [15:0] qB [$];
  bit ovA, unA, ovB, unB;

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  // registered-read monitor: every valid pulse must match a queued pop
  always @(negedge clk) begin
    if (bA.oRdValid === 1'b1) begin
      if (expA.size() == 0) begin
        total++;
        bad++;
        $display("FAIL A_unexpValid: got data %0h want no valid",
                 bA.oRdData);
      end else begin
        chk("A_rdData", bA.oRdData, expA.pop_front());
      end
    end
  end

  // fall-through monitor: head of model always on the output
  always @(negedge clk) begin
    if (armB) begin
      if (qB.size() > 0) begin
        chk("B_head", bB.oRdData, qB[0]);
        chk("B_valid", bB.oRdValid, 1);
      end else begin
        chk("B_emptyData", bB.oRdData, 0);
        chk("B_emptyValid", bB.oRdValid, 0);
      end
    end
  end

  task automatic stepA(input bit rst, input bit push,
                       input logic [7:0] d, input bit pop,
                       input bit clr);
    bit popOk, pushOk;
    int n;
    n = qA.size();
    rstA = rst;
    bA.iPush = push;
    bA.iWrData = d;
    bA.iPop = pop;
    bA.iClrErr = clr;
    popOk = pop && n > 0;
    pushOk = push && (n < 8 || popOk);
    @(posedge clk);
    if (rst) begin
      qA.delete();
      expA.delete();
      ovA = 0;
      unA = 0;
    end else begin
      if (popOk) expA.push_back(qA.pop_front());
      if (pushOk) qA.push_back(d);
      ovA = (push && !pushOk) || (ovA && !clr);
      unA = (pop && !popOk) || (unA && !clr);
    end
    #1;
    n = qA.size();
    chk("A_count", bA.oCount, n);
    chk("A_full", bA.oFull, n == 8);
    chk("A_empty", bA.oEmpty, n == 0);
    chk("A_afull", bA.oAlmostFull, n >= 6);
    chk("A_aempty", bA.oAlmostEmpty, n <= 1);
    chk("A_ovf", bA.oOverflow, ovA);
    chk("A_unf", bA.oUnderflow, unA);
    if (rst) begin
      chk("A_rstData", bA.oRdData, 0);
      chk("A_rstValid", bA.oRdValid, 0);
    end
  endtask

  task automatic stepB(input bit rst, input bit push,
                       input logic [15:0] d, input bit pop,
                       input bit clr);
    bit popOk, pushOk;
    int n;
    n = qB.size();
    rstB = rst;
    bB.iPush = push;
    bB.iWrData = d;
    bB.iPop = pop;
    bB.iClrErr = clr;
    popOk = pop && n > 0;
    pushOk = push && (n < 4 || popOk);
    if (popOk && !rst) chk("B_popData", bB.oRdData, qB[0]);
    @(posedge clk);
    if (rst) begin
      qB.delete();
      ovB = 0;
      unB = 0;
    end else begin
      if (popOk) void'(qB.pop_front());
      if (pushOk) qB.push_back(d);
      ovB = (push && !pushOk) || (ovB && !clr);
      unB = (pop && !popOk) || (unB && !clr);
    end
    #1;
    n = qB.size();
    chk("B_count", bB.oCount, n);
    chk("B_full", bB.oFull, n == 4);
    chk("B_empty", bB.oEmpty, n == 0);
    chk("B_afull", bB.oAlmostFull, n >= 3);
    chk("B_aempty", bB.oAlmostEmpty, n <= 1);
    chk("B_ovf", bB.oOverflow, ovB);
    chk("B_unf", bB.oUnderflow, unB);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    clk = 0;
    total = 0;
    bad = 0;
    armB = 0;
    rstA = 0;
    rstB = 0;
    bA.iPush = 0; bA.iWrData = 0; bA.iPop = 0; bA.iClrErr = 0;
    bB.iPush = 0; bB.iWrData = 0; bB.iPop = 0; bB.iClrErr = 0;
    #1;
    stepB(1, 0, 0, 0, 0);
    stepB(0, 0, 0, 0, 0);
    armB = 1;

    // reset, fill 1..8
    stepA(1, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) stepA(0, 1, 8'(i), 0, 0);
    // overflow then clear
    stepA(0, 1, 8'hAA, 0, 0);
    stepA(0, 0, 0, 0, 1);
    // full with push+pop: 0x01 out, 0x55 in last slot
    stepA(0, 1, 8'h55, 1, 0);
    for (int i = 0; i < 8; i++) stepA(0, 0, 0, 1, 0);
    // underflow, clear, then empty push+pop
    stepA(0, 0, 0, 1, 0);
    stepA(0, 0, 0, 0, 1);
    stepA(0, 1, 8'h33, 1, 0);
    stepA(0, 0, 0, 0, 1);
    stepA(0, 0, 0, 1, 0);
    // set and clear together: set wins
    stepA(0, 0, 0, 1, 1);
    stepA(0, 0, 0, 0, 1);
    stepA(0, 0, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 300; i++)
      stepA(0, $urandom_range(0, 9) < 6, 8'($urandom),
            $urandom_range(0, 9) < 5, $urandom_range(0, 9) == 0);
    // reset mid-operation with a simultaneous push
    for (int i = 0; i < 8; i++) stepA(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) stepA(0, 1, 8'(8'h40 + i), 0, 0);
    stepA(1, 1, 8'hEE, 0, 0);
    stepA(0, 1, 8'h77, 0, 0);
    stepA(0, 0, 0, 1, 0);
    stepA(0, 0, 0, 0, 0);
    stepA(0, 0, 0, 0, 0);
    chk("A_scoreboardDrained", expA.size(), 0);

    // fall-through: interleaved pushes and pops of 0x1000+i
    for (int i = 0; i < 20; i++)
      stepB(0, 1, 16'(16'h1000 + i), (i % 3) != 0, 0);
    for (int i = 0; i < 5; i++) stepB(0, 0, 0, 1, 0);
    stepB(0, 1, 16'hBEEF, 0, 1);
    for (int i = 0; i < 300; i++)
      stepB(0, $urandom_range(0, 9) < 5, 16'($urandom),
            $urandom_range(0, 9) < 5, $urandom_range(0, 9) == 0);
    stepB(1, 1, 16'h1234, 1, 0);
    stepB(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
